// File: rtl/os_result_collector.sv
// os_result_collector
// Reassembles the systolic array's bottom-edge drain into a ROWS x COLS
// result matrix. Beats arrive bottom row first, so beat k fills row ROWS-1-k.
// The finished matrix is held and offered downstream with valid/ready.
// Array size comes from the global ROWS / COLS header macros.
// Optional feature macro: OS_COLLECT_COLSUM_EN adds a per-column signed
// checksum output (col_sum) of every accepted word.

`ifndef ROWS
`define ROWS 3
`endif
`ifndef COLS
`define COLS 3
`endif

module os_result_collector #(
    parameter int WORD_SIZE = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [`COLS*WORD_SIZE-1:0]           bottom_out,
    input  logic [`COLS-1:0]                     output_col_valid,
    output logic [`ROWS*`COLS*WORD_SIZE-1:0]     result_matrix,
    output logic                                 result_valid,
    input  logic                                 result_ready,
    output logic                                 busy,
    output logic                                 partial,
    output logic                                 overflow
`ifdef OS_COLLECT_COLSUM_EN
    ,
    output logic [`COLS*(WORD_SIZE+$clog2(`ROWS)+1)-1:0] col_sum
`endif
);

    localparam int NR    = `ROWS;
    localparam int NC    = `COLS;
    localparam int CNT_W = $clog2(NR) + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] beat_cnt_reg;
    logic             partial_reg;
    logic             overflow_reg;

    logic beat;
    logic accept;

    assign beat   = |output_col_valid;
    // start discards a coincident beat, so it also blocks the buffer write
    assign accept = (state_reg == ST_COLLECT) && beat && !start;

    // Control FSM: start overrides every state, including a HOLD handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            beat_cnt_reg <= '0;
            partial_reg  <= 1'b0;
            overflow_reg <= 1'b0;
        end else if (start) begin
            state_reg    <= ST_COLLECT;
            beat_cnt_reg <= '0;
            partial_reg  <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                end
                ST_COLLECT: begin
                    if (beat) begin
                        beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
                        if (!(&output_col_valid))
                            partial_reg <= 1'b1;
                        if (beat_cnt_reg == CNT_W'(NR - 1))
                            state_reg <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (beat)
                        overflow_reg <= 1'b1;
                    if (result_ready)
                        state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Matrix buffer: one register per element, written when its row slot is current
    for (genvar gi = 0; gi < NR; gi++) begin : g_row
        // beat number that lands in this row (bottom row drains first)
        localparam logic [CNT_W-1:0] ROW_SLOT = CNT_W'(NR - 1 - gi);
        for (genvar gj = 0; gj < NC; gj++) begin : g_col
            logic [WORD_SIZE-1:0] elem_reg;

            // Capture this column's word on the beat that targets this row
            always_ff @(posedge clk) begin
                if (rst || start)
                    elem_reg <= '0;
                else if (accept && output_col_valid[gj] && (beat_cnt_reg == ROW_SLOT))
                    elem_reg <= bottom_out[gj*WORD_SIZE +: WORD_SIZE];
            end

            assign result_matrix[(gi*NC+gj)*WORD_SIZE +: WORD_SIZE] = elem_reg;
        end
    end

`ifdef OS_COLLECT_COLSUM_EN
    localparam int SUM_W = WORD_SIZE + $clog2(NR) + 1;

    for (genvar gi = 0; gi < NC; gi++) begin : g_sum
        logic [SUM_W-1:0] sum_reg;
        logic [SUM_W-1:0] word_ext;

        assign word_ext = {{(SUM_W-WORD_SIZE){bottom_out[(gi+1)*WORD_SIZE-1]}},
                           bottom_out[gi*WORD_SIZE +: WORD_SIZE]};

        // Signed running sum of the words accepted in this column
        always_ff @(posedge clk) begin
            if (rst || start)
                sum_reg <= '0;
            else if (accept && output_col_valid[gi])
                sum_reg <= sum_reg + word_ext;
        end

        assign col_sum[gi*SUM_W +: SUM_W] = sum_reg;
    end
`endif

    assign result_valid = (state_reg == ST_HOLD);
    assign busy         = (state_reg == ST_COLLECT);
    assign partial      = partial_reg;
    assign overflow     = overflow_reg;

endmodule

// File: tb/tb_os_result_collector.sv
// Testbench for os_result_collector (ROWS = COLS = 3, WORD_SIZE = 16).
// A matrix-level model tracks what has been collected; a compare process
// checks every output one step after each posedge, and directed literal
// checks pin the model to hand-computed values.

`ifndef ROWS
`define ROWS 3
`endif
`ifndef COLS
`define COLS 3
`endif

module tb_os_result_collector;

    localparam int W     = 16;
    localparam int SUM_W = 19;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [47:0]   bottom_out = '0;
    logic [2:0]    output_col_valid = '0;
    logic [143:0]  result_matrix;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic          busy;
    logic          partial;
    logic          overflow;
`ifdef OS_COLLECT_COLSUM_EN
    logic [3*SUM_W-1:0] col_sum;
`endif

    int checks = 0;
    int failures = 0;

    // Model state: collected matrix plus high-level phase flags
    logic [15:0] m_mat [0:2][0:2];
    bit          m_coll = 0;
    bit          m_hold = 0;
    bit          m_part = 0;
    bit          m_ovf  = 0;
    int          m_nb   = 0;

    os_result_collector #(.WORD_SIZE(W)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .bottom_out       (bottom_out),
        .output_col_valid (output_col_valid),
        .result_matrix    (result_matrix),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .busy             (busy),
        .partial          (partial),
        .overflow         (overflow)
`ifdef OS_COLLECT_COLSUM_EN
        ,
        .col_sum          (col_sum)
`endif
    );

    always #5 clk = ~clk;

    // Beat data, packed {col2, col1, col0}
    localparam logic [47:0] B1 = {16'd3, 16'd2, 16'd1};
    localparam logic [47:0] B2 = {16'd6, 16'd5, 16'd4};
    localparam logic [47:0] B3 = {16'd9, 16'd8, 16'd7};
    localparam logic [47:0] N1 = {16'hFFFF, 16'd2, 16'hFFFF};
    localparam logic [47:0] N2 = {16'hFFFF, 16'd5, 16'd4};
    localparam logic [47:0] N3 = {16'hFFFF, 16'd8, 16'd7};

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] elem(input logic [143:0] m, input int r, input int c);
        return m[(r*3+c)*16 +: 16];
    endfunction

    function automatic logic [143:0] model_packed();
        logic [143:0] p;
        p = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                p[(r*3+c)*16 +: 16] = m_mat[r][c];
        return p;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                m_mat[r][c] = '0;
        m_part = 0;
        m_ovf  = 0;
        m_nb   = 0;
    endtask

    initial model_clear();

    // Drive one cycle of inputs on the negedge and advance the model to the
    // state the DUT must show after the following posedge.
    task automatic step(input bit r, input bit s, input logic [2:0] v,
                        input logic [47:0] d, input bit rdy);
        @(negedge clk);
        rst = r;
        start = s;
        output_col_valid = v;
        bottom_out = d;
        result_ready = rdy;
        if (r) begin
            model_clear();
            m_coll = 0;
            m_hold = 0;
        end else if (s) begin
            model_clear();
            m_coll = 1;
            m_hold = 0;
        end else if (m_coll && v != 3'b000) begin
            for (int c = 0; c < 3; c++)
                if (v[c]) m_mat[2-m_nb][c] = d[c*16 +: 16];
            if (v != 3'b111) m_part = 1;
            m_nb++;
            if (m_nb == 3) begin
                m_coll = 0;
                m_hold = 1;
            end
        end else if (m_hold) begin
            if (v != 3'b000) m_ovf = 1;
            if (rdy) m_hold = 0;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 3'b000, '0, 0);
    endtask

    // Compare every output against the model just after each posedge
    always @(posedge clk) begin
        #1;
        chk("matrix", result_matrix, model_packed());
        chk("result_valid", {143'd0, result_valid}, {143'd0, m_hold});
        chk("busy", {143'd0, busy}, {143'd0, m_coll});
        chk("partial", {143'd0, partial}, {143'd0, m_part});
        chk("overflow", {143'd0, overflow}, {143'd0, m_ovf});
`ifdef OS_COLLECT_COLSUM_EN
        for (int c = 0; c < 3; c++) begin
            int s;
            logic [SUM_W-1:0] e;
            s = 0;
            for (int r = 0; r < 3; r++) s += $signed(m_mat[r][c]);
            e = SUM_W'(s);
            chk("col_sum", {125'd0, col_sum[c*SUM_W +: SUM_W]}, {125'd0, e});
        end
`endif
    end

    logic [143:0] saved;

    initial begin
        // Reset
        step(1, 0, 3'b000, '0, 0);
        step(1, 0, 3'b000, '0, 0);
        step(0, 0, 3'b000, '0, 0);
        chk("reset_matrix", result_matrix, 144'd0);
        chk("reset_valid", {143'd0, result_valid}, 144'd0);

        // Basic drain
        step(0, 1, 3'b000, '0, 0);
        chk("busy_after_start", {143'd0, busy}, 144'd1);
        step(0, 0, 3'b111, B1, 0);
        step(0, 0, 3'b111, B2, 0);
        chk("valid_before_last", {143'd0, result_valid}, 144'd0);
        step(0, 0, 3'b111, B3, 0);
        chk("valid_after_last", {143'd0, result_valid}, 144'd1);
        chk("e20", {128'd0, elem(result_matrix, 2, 0)}, 144'd1);
        chk("e22", {128'd0, elem(result_matrix, 2, 2)}, 144'd3);
        chk("e00", {128'd0, elem(result_matrix, 0, 0)}, 144'd7);
        chk("e02", {128'd0, elem(result_matrix, 0, 2)}, 144'd9);
        chk("e11", {128'd0, elem(result_matrix, 1, 1)}, 144'd5);
        chk("basic_partial", {143'd0, partial}, 144'd0);
`ifdef OS_COLLECT_COLSUM_EN
        chk("colsum0_basic", {125'd0, col_sum[0 +: SUM_W]}, 144'd12);
`endif
        saved = result_matrix;

        // Handshake stall then accept
        idle(5);
        chk("hold_stable", result_matrix, saved);
        chk("hold_valid", {143'd0, result_valid}, 144'd1);
        step(0, 0, 3'b000, '0, 1);
        chk("valid_drop", {143'd0, result_valid}, 144'd0);
        chk("idle_busy", {143'd0, busy}, 144'd0);
        chk("buffer_kept", result_matrix, saved);

        // Gapped beats, then an extra beat in HOLD
        step(0, 1, 3'b000, '0, 0);
        step(0, 0, 3'b111, B1, 0);
        idle(1);
        step(0, 0, 3'b111, B2, 0);
        idle(1);
        step(0, 0, 3'b111, B3, 0);
        chk("gap_matrix", result_matrix, saved);
        step(0, 0, 3'b111, B1, 0);
        chk("overflow_set", {143'd0, overflow}, 144'd1);
        chk("overflow_matrix", result_matrix, saved);
        // start coinciding with the handshake restarts collection
        step(0, 1, 3'b111, B2, 1);
        chk("restart_busy", {143'd0, busy}, 144'd1);
        chk("restart_clear", result_matrix, 144'd0);

        // Partial beat
        step(0, 0, 3'b111, B1, 0);
        step(0, 0, 3'b101, B2, 0);
        step(0, 0, 3'b111, B3, 0);
        chk("partial_e11", {128'd0, elem(result_matrix, 1, 1)}, 144'd0);
        chk("partial_e10", {128'd0, elem(result_matrix, 1, 0)}, 144'd4);
        chk("partial_flag", {143'd0, partial}, 144'd1);
        step(0, 0, 3'b000, '0, 1);

        // Abort after two beats
        step(0, 1, 3'b000, '0, 0);
        step(0, 0, 3'b111, B1, 0);
        step(0, 0, 3'b111, B2, 0);
        step(0, 1, 3'b000, '0, 0);
        chk("abort_clear", result_matrix, 144'd0);
        step(0, 0, 3'b111, B1, 0);
        step(0, 0, 3'b111, B2, 0);
        chk("abort_not_done", {143'd0, result_valid}, 144'd0);
        step(0, 0, 3'b111, B3, 0);
        chk("abort_done", {143'd0, result_valid}, 144'd1);

        // Reset in HOLD
        step(1, 0, 3'b000, '0, 0);
        chk("rst_matrix", result_matrix, 144'd0);
        chk("rst_valid", {143'd0, result_valid}, 144'd0);
        step(0, 0, 3'b000, '0, 0);

        // Negative-value variant
        step(0, 1, 3'b000, '0, 0);
        step(0, 0, 3'b111, N1, 0);
        step(0, 0, 3'b111, N2, 0);
        step(0, 0, 3'b111, N3, 0);
        chk("neg_e20", {128'd0, elem(result_matrix, 2, 0)}, 144'hFFFF);
`ifdef OS_COLLECT_COLSUM_EN
        chk("colsum0_neg", {125'd0, col_sum[0 +: SUM_W]}, 144'd10);
        chk("colsum2_neg", {125'd0, col_sum[2*SUM_W +: SUM_W]}, 144'h7FFFD);
`endif
        step(0, 0, 3'b000, '0, 1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
